// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage hazard controller.
// Holds register-file geometry, the forwarding-select encodings that the
// forwarding mux and the hazard logic must agree on, and a source-match helper.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W  = 4;
    localparam int unsigned NUM_REGS    = 16;
    localparam int unsigned STALL_CNT_W = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Forwarding-select encodings shared with the EX-stage operand muxes.
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    // True when a source that is actually read names a non-x0 producer register.
    function automatic logic src_match(input logic uses, input reg_addr_t rs, input reg_addr_t rd);
        return uses && (rs == rd) && (rd != '0);
    endfunction

endpackage

// File: rtl/hazard_unit_long_op_scoreboard.sv
// Tracks the single in-flight long-latency operation.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   issue, issue_rd   long op leaves ID this cycle, and its destination
//   pending           one bit per register awaiting a long-unit writeback
//   busy              long op in flight (countdown nonzero)
//   wb_valid          writeback strobe (last countdown cycle)
//   wb_rd             destination latched at issue
module long_op_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned LONG_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  busy,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd
);

    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [REG_ADDR_W-1:0] rd_q,      rd_d;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            pending_q <= '0;
            rd_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            rd_q      <= rd_d;
        end
    end

    // Countdown, pending-bit retire on the strobe edge, load on issue.
    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        rd_d      = rd_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q == CNT_W'(1)) begin
            pending_d[rd_q] = 1'b0;
        end
        // Issue is blocked while busy, so it never overlaps the retire above.
        if (issue) begin
            cnt_d = CNT_W'(LONG_LAT);
            rd_d  = issue_rd;
            if (issue_rd != '0) begin
                pending_d[issue_rd] = 1'b1;
            end
        end
    end

    assign pending  = pending_q;
    assign busy     = (cnt_q != '0);
    assign wb_valid = (cnt_q == CNT_W'(1));
    assign wb_rd    = rd_q;

endmodule

// File: rtl/hazard_unit.sv
// Decode-stage hazard controller: load-use and long-op scoreboard stalls,
// taken-branch flushes, and a saturating stall-cycle counter.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_*                           ID-stage instruction fields
//   ex_rd, ex_mem_read             EX destination and load flag
//   ex_branch_taken                EX resolved a taken branch/jump
//   pc_write, ifid_write           front-end advance enables
//   ifid_flush, idex_bubble        flush IF/ID, insert NOP into ID/EX
//   lu_busy, lu_wb_valid, lu_wb_rd long-unit status and writeback strobe
//   stall_cycles                   saturating stall-cycle count
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned LONG_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_long_op,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   ex_branch_taken,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   lu_busy,
    output logic                   lu_wb_valid,
    output logic [REG_ADDR_W-1:0]  lu_wb_rd,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic [NUM_REGS-1:0]    pending;
    logic                   load_use;
    logic                   raw_pend;
    logic                   waw_pend;
    logic                   struct_haz;
    logic                   stall;
    logic                   issue;
    logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    long_op_scoreboard #(
        .LONG_LAT (LONG_LAT)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .issue    (issue),
        .issue_rd (id_rd),
        .pending  (pending),
        .busy     (lu_busy),
        .wb_valid (lu_wb_valid),
        .wb_rd    (lu_wb_rd)
    );

    // Hazard detection; pending[0] is never set so x0 sources cannot stall.
    always_comb begin
        load_use   = ex_mem_read &&
                     (src_match(id_uses_rs1, id_rs1, ex_rd) ||
                      src_match(id_uses_rs2, id_rs2, ex_rd));
        raw_pend   = (id_uses_rs1 && pending[id_rs1]) ||
                     (id_uses_rs2 && pending[id_rs2]);
        waw_pend   = id_reg_write && (id_rd != '0) && pending[id_rd];
        struct_haz = id_long_op && lu_busy;
        // A taken branch discards the ID instruction, so it overrides any stall.
        stall      = id_valid && !ex_branch_taken &&
                     (load_use || raw_pend || waw_pend || struct_haz);
        issue      = id_valid && id_long_op && !stall && !ex_branch_taken;
    end

    assign pc_write     = !stall;
    assign ifid_write   = !stall;
    assign idex_bubble  = stall || ex_branch_taken;
    assign ifid_flush   = ex_branch_taken;
    assign stall_cycles = stall_cycles_q;

    // Stall-cycle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Saturating increment.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus random traffic,
// compared every cycle against a timestamp-based model of the long unit.
module tb_hazard_unit;

    localparam int L = 4;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [3:0]  id_rd;
    logic        id_reg_write;
    logic        id_long_op;
    logic [3:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        lu_busy;
    logic        lu_wb_valid;
    logic [3:0]  lu_wb_rd;
    logic [15:0] stall_cycles;

    hazard_unit #(.LONG_LAT(L)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_long_op      (id_long_op),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .lu_busy         (lu_busy),
        .lu_wb_valid     (lu_wb_valid),
        .lu_wb_rd        (lu_wb_rd),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: the in-flight op is described by the cycle index its countdown
    // started on and its destination; busy/strobe/pending follow from its age.
    int         cyc      = 0;
    bit         m_active = 1'b0;
    int         m_start  = 0;
    logic [3:0] m_rd     = 4'd0;
    int         m_stalls = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_pend(input bit busy, input logic [3:0] r);
        return busy && (r != 4'd0) && (r == m_rd);
    endfunction

    // Called at a negedge with inputs applied; checks, then advances one cycle.
    task automatic step();
        int age;
        bit busy, wb, lu, raw, waw, st, e_stall, e_issue;
        #1;
        age     = cyc - m_start;
        busy    = m_active && (age < L);
        wb      = m_active && (age == L - 1);
        lu      = ex_mem_read && (ex_rd != 4'd0) &&
                  ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        raw     = (id_uses_rs1 && m_pend(busy, id_rs1)) || (id_uses_rs2 && m_pend(busy, id_rs2));
        waw     = id_reg_write && m_pend(busy, id_rd);
        st      = id_long_op && busy;
        e_stall = id_valid && !ex_branch_taken && (lu || raw || waw || st);
        e_issue = id_valid && id_long_op && !e_stall && !ex_branch_taken;

        check("pc_write",     32'(pc_write),     32'(!e_stall));
        check("ifid_write",   32'(ifid_write),   32'(!e_stall));
        check("ifid_flush",   32'(ifid_flush),   32'(ex_branch_taken));
        check("idex_bubble",  32'(idex_bubble),  32'(e_stall || ex_branch_taken));
        check("lu_busy",      32'(lu_busy),      32'(busy));
        check("lu_wb_valid",  32'(lu_wb_valid),  32'(wb));
        check("lu_wb_rd",     32'(lu_wb_rd),     32'(m_rd));
        check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));

        @(posedge clk);
        if (rst) begin
            m_active = 1'b0;
            m_rd     = 4'd0;
            m_stalls = 0;
        end else begin
            if (e_stall && m_stalls < 65535) m_stalls++;
            if (wb) m_active = 1'b0;
            if (e_issue) begin
                m_active = 1'b1;
                m_start  = cyc + 1;
                m_rd     = id_rd;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; id_valid = 1'b0; id_rs1 = 4'd0; id_rs2 = 4'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_rd = 4'd0; id_reg_write = 1'b0;
        id_long_op = 1'b0; ex_rd = 4'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic long_op(input logic [3:0] rd);
        idle();
        id_valid = 1'b1; id_long_op = 1'b1; id_reg_write = 1'b1; id_rd = rd;
    endtask

    task automatic reader(input logic [3:0] rs);
        idle();
        id_valid = 1'b1; id_uses_rs1 = 1'b1; id_rs1 = rs;
    endtask

    task automatic load_use_x5();
        idle();
        ex_mem_read = 1'b1; ex_rd = 4'd5;
        id_valid = 1'b1; id_uses_rs2 = 1'b1; id_rs2 = 4'd5;
    endtask

    function automatic logic [3:0] rreg();
        logic [3:0] tbl [6];
        tbl[0] = 4'd0; tbl[1] = 4'd1; tbl[2] = 4'd2;
        tbl[3] = 4'd3; tbl[4] = 4'd5; tbl[5] = 4'd7;
        return tbl[$urandom_range(0, 5)];
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        step();
        step();
        idle();
        step();
        step();

        // Load-use: one stall, then the load has left EX.
        load_use_x5();
        step();
        ex_mem_read = 1'b0;
        step();

        // Long op to x3 followed by a dependent.
        long_op(4'd3);
        step();
        reader(4'd3);
        repeat (L + 1) step();

        // Back-to-back long ops: x7 waits for the unit, then its reader waits.
        long_op(4'd2);
        step();
        long_op(4'd7);
        repeat (L + 1) step();
        reader(4'd7);
        repeat (L + 1) step();

        // Taken branch together with load-use and an issue request.
        load_use_x5();
        id_long_op = 1'b1; id_rd = 4'd6; ex_branch_taken = 1'b1;
        step();
        idle();
        step();

        // Long op to x0, then a reader of x0.
        long_op(4'd0);
        step();
        reader(4'd0);
        repeat (L + 1) step();

        // Reset while the countdown is at 2.
        long_op(4'd3);
        step();
        reader(4'd3);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (L + 2) step();

        // Random traffic.
        repeat (3000) begin
            rst             = ($urandom_range(0, 99) == 0);
            id_valid        = ($urandom_range(0, 9) != 0);
            id_rs1          = rreg();
            id_rs2          = rreg();
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            id_rd           = rreg();
            id_reg_write    = 1'($urandom_range(0, 1));
            id_long_op      = ($urandom_range(0, 3) == 0);
            ex_rd           = rreg();
            ex_mem_read     = ($urandom_range(0, 3) == 0);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            step();
        end

        // Saturation of the stall counter.
        idle();
        rst = 1'b1;
        step();
        load_use_x5();
        repeat (65540) step();
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
